word_serializer: RTL and testbench
==================================

// Module: word_serializer
// PURPOSE
//   Parallel-in/serial-out stage that feeds the serial input b of the three-zeros detector.
//   - Accepts a WIDTH-bit word through a load/ready handshake.
//   - Shifts the word out one bit per clock on b, with a bit_valid qualifier.
//   - Idle line level is IDLE_BIT, so gaps between words never fake a zero run downstream.
// PARAMETERS
//   WIDTH      8   bits per word, >= 2
//   MSB_FIRST  1   1: data_in[WIDTH-1] is sent first; 0: data_in[0] is sent first
//   IDLE_BIT   1   level driven on b whenever no word is being shifted
// PORTS
//   clock      in   1      single clock; all state changes on posedge
//   reset      in   1      synchronous, active-high
//   data_in    in   WIDTH  word to serialize; sampled only when load && ready
//   load       in   1      request to accept data_in this cycle
//   ready      out  1      block can accept a word this cycle (combinational from state/count)
//   b          out  1      serial bit stream (registered)
//   bit_valid  out  1      b carries a data bit this cycle (registered)
//   busy       out  1      a word is in flight (state == SHIFT)
//   done       out  1      high for exactly the cycle in which a word's last bit is on b
// BEHAVIOUR
//   Reset (sync, at posedge with reset=1) forces:
//     - state=IDLE, count=0, b=IDLE_BIT, bit_valid=0, busy=0, done=0, ready=1.
//     - Any word in flight is discarded.
//   Reset priority: reset wins over a simultaneous load; that word is dropped and ready=1 next cycle.
//   FSM has two states, IDLE and SHIFT:
//     IDLE:  ready=1, b=IDLE_BIT, bit_valid=0.
//            load sampled at edge k -> capture word, go to SHIFT, count=0.
//            First bit appears on b in the cycle after edge k (latency 1).
//     SHIFT: b=current bit, bit_valid=1.
//            count increments 0..WIDTH-1; count is $clog2(WIDTH) bits and never wraps past WIDTH-1.
//            count==WIDTH-1 is the last-bit cycle: done=1 and ready=1.
//     SHIFT exit, taken at the edge that ends the last-bit cycle:
//       - load=1: capture the new word, stay in SHIFT, count=0.
//         Back-to-back words therefore have zero idle gap.
//       - load=0: go to IDLE; b returns to IDLE_BIT, bit_valid=0.
//   Handshake:
//     - Transfer occurs only when load && ready at a posedge.
//     - load while ready=0 is ignored: no capture, no error flag, and the current word is not disturbed.
//     - data_in may change freely when no transfer occurs.
//   Bit order:
//     - MSB_FIRST=1: shift left, b = sr[WIDTH-1].
//     - MSB_FIRST=0: shift right, b = sr[0].
//     - Shift-in fill value is IDLE_BIT; fill is never output.
//   A word occupies exactly WIDTH cycles of bit_valid=1; throughput is 1 bit/clock.
// STRUCTURE
//   Shared package hw5_pkg:
//     - typedef enum logic {SER_IDLE, SER_SHIFT} ser_state_t.
//     - localparam SER_IDLE_BIT default.
//   One sub-module: piso_shreg.
//     - WIDTH-bit shift register with load / shift enable and the MSB_FIRST select.
//     - Holds no control logic.
//   Top: FSM, bit counter, output registers, and the ready/done decode.
// TESTING (WIDTH=8, MSB_FIRST=1, IDLE_BIT=1, detector chained on b)
//   1 Reset, then idle 5 cycles
//     -> b=1, bit_valid=0, ready=1, detector found3zeros_N stays 1.
//   2 load 8'b1000_1011 at edge k
//     -> b = 1,0,0,0,1,0,1,1 in cycles k+1..k+8.
//     -> done only in cycle k+8; detector asserts found3zeros_N=0 after the third zero.
//   3 Back-to-back: load 8'hA5, then load 8'h3C during A5's done cycle
//     -> 16 consecutive bit_valid=1 cycles carrying 10100101_00111100, no idle gap.
//   4 load 8'hFF, then pulse load with 8'h00 at bit 3
//     -> ignored; b stays all 1s, one done, then IDLE.
//   5 load 8'h0F, assert reset after 3 bits
//     -> next cycle b=1, bit_valid=0, busy=0, ready=1; no done pulse.
//     -> Same-edge reset+load 8'h00 -> word dropped.
//   6 MSB_FIRST=0, load 8'b0000_0001
//     -> b = 1,0,0,0,0,0,0,0; done on the 8th bit.

Source files
------------

// File: rtl/hw5_pkg.sv
// Shared types for the serial front-end of the three-zeros detector.
package hw5_pkg;

  typedef enum logic {SER_IDLE, SER_SHIFT} ser_state_t;

  // Idle line level: a run of ones cannot look like a zero run downstream.
  localparam logic SER_IDLE_BIT = 1'b1;

endpackage

// File: rtl/piso_shreg.sv
// WIDTH-bit parallel-in/serial-out register; head is the bit currently on the line.
// Latency 1 from load to head; no flow control of its own (the top decides when to load/shift).
module piso_shreg #(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic FILL      = 1'b1
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] data_in,
  output logic             head
);

  logic [WIDTH-1:0] sr;

  // After WIDTH shifts the register holds only FILL, so head returns to the idle level by itself.
  always_ff @(posedge clock) begin
    if (clear) begin
      sr <= {WIDTH{FILL}};
    end else if (load) begin
      sr <= data_in;
    end else if (shift) begin
      if (MSB_FIRST) begin
        sr <= {sr[WIDTH-2:0], FILL};
      end else begin
        sr <= {FILL, sr[WIDTH-1:1]};
      end
    end
  end

  assign head = MSB_FIRST ? sr[WIDTH-1] : sr[0];

endmodule

// File: rtl/word_serializer.sv
// Serializes WIDTH-bit words onto b, first bit one cycle after the accepting edge.
// ready drops while a word is shifting and returns in its last-bit cycle, so words chain gap-free.
module word_serializer
  import hw5_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = SER_IDLE_BIT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             ready,
  output logic             b,
  output logic             bit_valid,
  output logic             busy,
  output logic             done
);

  localparam int               CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  ser_state_t       state;
  ser_state_t       state_next;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             last;
  logic             capture;

  assign last = (count == LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= SER_IDLE;
      count     <= '0;
      bit_valid <= 1'b0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      bit_valid <= (state_next == SER_SHIFT);
    end
  end

  always_comb begin
    state_next = state;
    count_next = count;
    ready      = 1'b0;
    done       = 1'b0;
    capture    = 1'b0;
    case (state)
      SER_IDLE: begin
        ready = 1'b1;
        if (load) begin
          capture    = 1'b1;
          state_next = SER_SHIFT;
          count_next = '0;
        end
      end
      SER_SHIFT: begin
        if (last) begin
          ready      = 1'b1;
          done       = 1'b1;
          count_next = '0;
          if (load) begin
            capture = 1'b1;
          end else begin
            state_next = SER_IDLE;
          end
        end else begin
          count_next = count + 1'b1;
        end
      end
      default: begin
        state_next = SER_IDLE;
        count_next = '0;
      end
    endcase
  end

  assign busy = (state == SER_SHIFT);

  piso_shreg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST),
    .FILL      (IDLE_BIT)
  ) u_shreg (
    .clock   (clock),
    .clear   (reset),
    .load    (capture),
    .shift   (busy),
    .data_in (data_in),
    .head    (b)
  );

endmodule

// File: tb/tb_word_serializer.sv
// Drives an MSB-first and an LSB-first serializer with shared stimulus, checked against a bit-queue model.
module tb_word_serializer;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic         load;
  logic [W-1:0] data_in;

  logic ready_m, b_m, bv_m, busy_m, done_m;
  logic ready_l, b_l, bv_l, busy_l, done_l;

  int n_cmp = 0;
  int n_err = 0;
  bit model_on = 1'b0;

  // Expected line contents: each queue holds the bits still to appear on b, front = current bit.
  bit qm[$];
  bit ql[$];

  always #5 clock = ~clock;

  word_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) dut_m (
    .clock(clock), .reset(reset), .data_in(data_in), .load(load),
    .ready(ready_m), .b(b_m), .bit_valid(bv_m), .busy(busy_m), .done(done_m)
  );

  word_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_l (
    .clock(clock), .reset(reset), .data_in(data_in), .load(load),
    .ready(ready_l), .b(b_l), .bit_valid(bv_l), .busy(busy_l), .done(done_l)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  // A word is accepted when at most its final bit remains; every edge consumes one bit.
  always @(posedge clock) begin : model
    bit rdy;
    rdy = (qm.size() <= 1);
    if (reset) begin
      qm.delete();
      ql.delete();
    end else begin
      if (qm.size() > 0) void'(qm.pop_front());
      if (ql.size() > 0) void'(ql.pop_front());
      if (load && rdy) begin
        for (int i = 0; i < W; i++) begin
          qm.push_back(data_in[W-1-i]);
          ql.push_back(data_in[i]);
        end
      end
    end
  end

  always @(negedge clock) begin
    if (model_on) begin
      check("m_b",     32'(b_m),     32'((qm.size() > 0) ? qm[0] : 1'b1));
      check("m_valid", 32'(bv_m),    32'(qm.size() > 0));
      check("m_busy",  32'(busy_m),  32'(qm.size() > 0));
      check("m_done",  32'(done_m),  32'(qm.size() == 1));
      check("m_ready", 32'(ready_m), 32'(qm.size() <= 1));
      check("l_b",     32'(b_l),     32'((ql.size() > 0) ? ql[0] : 1'b1));
      check("l_valid", 32'(bv_l),    32'(ql.size() > 0));
      check("l_busy",  32'(busy_l),  32'(ql.size() > 0));
      check("l_done",  32'(done_l),  32'(ql.size() == 1));
      check("l_ready", 32'(ready_l), 32'(ql.size() <= 1));
    end
  end

  initial begin
    logic [W-1:0]   sm;
    logic [W-1:0]   sl;
    logic [2*W-1:0] stream;
    int             ndone;

    reset   = 1'b1;
    load    = 1'b0;
    data_in = '0;
    cycle();
    cycle();
    reset    = 1'b0;
    model_on = 1'b1;

    // Idle after reset
    for (int i = 0; i < 5; i++) begin
      check("t1_b",     32'(b_m),     32'd1);
      check("t1_valid", 32'(bv_m),    32'd0);
      check("t1_ready", 32'(ready_m), 32'd1);
      cycle();
    end

    // Single word 1000_1011
    data_in = 8'h8B;
    load    = 1'b1;
    cycle();
    load = 1'b0;
    for (int i = 0; i < W; i++) begin
      sm[W-1-i] = b_m;
      sl[i]     = b_l;
      check("t2_valid", 32'(bv_m), 32'd1);
      check("t2_done",  32'(done_m), 32'(i == W - 1));
      cycle();
    end
    check("t2_msb_seq", 32'(sm), 32'h8B);
    check("t2_lsb_seq", 32'(sl), 32'h8B);
    check("t2_idle",    32'(bv_m), 32'd0);

    // Back-to-back A5 then 3C
    data_in = 8'hA5;
    load    = 1'b1;
    cycle();
    for (int i = 0; i < 2 * W; i++) begin
      stream[2*W-1-i] = b_m;
      check("t3_valid", 32'(bv_m), 32'd1);
      if (i == W - 1) begin
        load    = 1'b1;
        data_in = 8'h3C;
      end else begin
        load = 1'b0;
      end
      cycle();
    end
    check("t3_stream", 32'(stream), 32'hA53C);
    check("t3_idle",   32'(bv_m),   32'd0);

    // Load while not ready is ignored
    data_in = 8'hFF;
    load    = 1'b1;
    cycle();
    ndone = 0;
    for (int i = 0; i < W; i++) begin
      sm[W-1-i] = b_m;
      if (done_m) ndone++;
      if (i == 3) begin
        load    = 1'b1;
        data_in = 8'h00;
      end else begin
        load = 1'b0;
      end
      cycle();
    end
    check("t4_seq",   32'(sm),     32'hFF);
    check("t4_dones", 32'(ndone),  32'd1);
    check("t4_idle",  32'(bv_m),   32'd0);
    check("t4_busy",  32'(busy_m), 32'd0);

    // Reset mid-word, then reset colliding with load
    data_in = 8'h0F;
    load    = 1'b1;
    cycle();
    load = 1'b0;
    cycle();
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("t5_b",     32'(b_m),     32'd1);
    check("t5_valid", 32'(bv_m),    32'd0);
    check("t5_busy",  32'(busy_m),  32'd0);
    check("t5_ready", 32'(ready_m), 32'd1);
    check("t5_done",  32'(done_m),  32'd0);
    data_in = 8'h00;
    load    = 1'b1;
    reset   = 1'b1;
    cycle();
    reset = 1'b0;
    load  = 1'b0;
    check("t5_drop_valid", 32'(bv_m),    32'd0);
    check("t5_drop_ready", 32'(ready_m), 32'd1);
    cycle();
    check("t5_drop_later", 32'(bv_m), 32'd0);

    // LSB-first order of 0000_0001
    data_in = 8'h01;
    load    = 1'b1;
    cycle();
    load = 1'b0;
    for (int i = 0; i < W; i++) begin
      sl[W-1-i] = b_l;
      check("t6_done", 32'(done_l), 32'(i == W - 1));
      cycle();
    end
    check("t6_seq", 32'(sl), 32'h80);

    // Random traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      load    = 1'($urandom_range(0, 1));
      data_in = W'($urandom);
      reset   = ($urandom_range(0, 63) == 0);
      cycle();
    end
    reset = 1'b0;
    load  = 1'b0;
    repeat (12) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
